psx_mem_arbiter: RTL and testbench
==================================

PSX_MEM_ARBITER -- requirements
Module: psx_mem_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning the number of idle cycles (0..7) between one transaction completing and the next command issuing.
REQ-002 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_reqCmd  input  3  request per requester (bit n = requester n: 0 GPU, 1 MDEC, 2 CPU).
REQ-005 SHALL have port i_reqWrite  input  3  per requester: 1 = write, 0 = read.
REQ-006 SHALL have port i_reqSize  input  6  per requester, 2 bits each (0 = 8 byte, 1 = 32 byte, 2 = 4 byte).
REQ-007 SHALL have port i_reqAddr  input  45  per requester, 15 bits each; 32-byte block address.
REQ-008 SHALL have port i_reqSub  input  9  per requester, 3 bits each; 4-byte sub-address.
REQ-009 SHALL have port i_reqMask  input  48  per requester, 16 bits each; 16-bit-lane write mask.
REQ-010 SHALL have port i_reqData  input  768  per requester, 256 bits each; write data.
REQ-011 SHALL have port o_ack  output  3  one-cycle pulse when the request is accepted and latched.
REQ-012 SHALL have port o_done  output  3  one-cycle pulse when the owner's transaction completes.
REQ-013 SHALL have port o_rdValid  output  3  read data valid for the owner.
REQ-014 SHALL have port o_rdData  output  256  read data, shared by all requesters.
REQ-015 SHALL have bridge-side outputs o_command (1), o_writeElseRead (1), o_commandSize (2), o_targetAddr (15), o_subAddr (3), o_writeMask (16) and o_dataClient (256).
REQ-016 SHALL have bridge-side inputs i_busyClient (1), i_dataValidClient (1) and i_dataClient (256).

Function
REQ-017 SHALL implement the states IDLE, CMD, ARM, BUSY and GAP.
REQ-018 IDLE: if any i_reqCmd bit is set, SHALL select a winner (REQ-027), latch all of its fields into holding registers, pulse o_ack[winner] and go to CMD in the same edge.
REQ-019 CMD: SHALL drive o_command=1 for exactly one cycle, then go to ARM.
REQ-020 ARM: SHALL wait one cycle, because bridge busy is only visible the cycle after the command, then go to BUSY.
REQ-021 BUSY: when i_busyClient=0, SHALL pulse o_done[owner], then go to GAP, or to IDLE if GAP_CYCLES=0.
REQ-022 GAP: SHALL count GAP_CYCLES cycles, then go to IDLE.
REQ-023 Holding registers SHALL drive the bridge fields continuously from CMD through BUSY, because the bridge samples the command size combinationally for the whole burst; they SHALL hold their last value otherwise.
REQ-024 o_rdValid[owner] SHALL equal i_dataValidClient AND owner-is-read, and o_rdData SHALL equal i_dataClient, both combinationally; o_rdValid SHALL be 0 for writes.
REQ-025 i_dataValidClient arriving outside BUSY SHALL be ignored (o_rdValid=0).
REQ-026 Requesters SHALL keep i_reqCmd and their fields stable until o_ack; deasserting before o_ack withdraws the request with no effect.
REQ-027 Arbitration SHALL be evaluated only in IDLE; a requester holding i_reqCmd through o_done SHALL be treated as a new request.
REQ-028 o_command SHALL never be asserted while the state is not CMD, and SHALL never be asserted on two consecutive cycles.
REQ-029 Simultaneous requests SHALL produce exactly one o_ack bit per grant.

Reset
REQ-030 While i_rst=1: state SHALL be IDLE, GAP counter 0, owner 0, o_command/o_ack/o_done/o_rdValid 0, and holding registers 0.
REQ-031 Reset asserted mid-transaction SHALL abort without o_done; after release the block SHALL issue only for new requests.

Configuration
REQ-032 With PSX_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index after the last granted index, cyclically (last granted resets to 2, so requester 0 wins first).
REQ-033 Without PSX_ARB_ROUND_ROBIN_EN, the winner SHALL be fixed priority 0 > 1 > 2, and no last-grant register SHALL exist.

Verification
REQ-034 Single GPU 32-byte read, addr 0x1234, sub 0: bridge model busy for 6 cycles -> o_ack[0] at edge 1, o_command high one cycle, o_commandSize=1 stable until busy falls, then o_rdValid[0] and o_done[0] with the model's data.
REQ-035 CPU 4-byte write, sub 1, data 0xDEADBEEF -> o_writeElseRead=1, o_subAddr=1, o_dataClient[31:0]=0xDEADBEEF, then o_done[2] with o_rdValid all zero.
REQ-036 All three requesters held continuously, round-robin build -> grant order 0,1,2,0,1,2; fixed-priority build -> requester 0 only.
REQ-037 GAP_CYCLES=3 -> exactly 3 idle cycles between o_done and the next o_command.
REQ-038 Assert i_rst during BUSY -> all outputs 0 within the same cycle, no o_done, and a new request after release is acked normally.
REQ-039 Spurious i_dataValidClient in IDLE -> o_rdValid stays 0.

Source files
------------

// File: rtl/psx_mem_arbiter.sv
// Three-way arbiter (GPU, MDEC, CPU) in front of a single memory bridge.
// Define PSX_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority 0 > 1 > 2.
module psx_mem_arbiter #(
  parameter int GAP_CYCLES = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [2:0]   i_reqCmd,
  input  logic [2:0]   i_reqWrite,
  input  logic [5:0]   i_reqSize,
  input  logic [44:0]  i_reqAddr,
  input  logic [8:0]   i_reqSub,
  input  logic [47:0]  i_reqMask,
  input  logic [767:0] i_reqData,
  output logic [2:0]   o_ack,
  output logic [2:0]   o_done,
  output logic [2:0]   o_rdValid,
  output logic [255:0] o_rdData,
  output logic         o_command,
  output logic         o_writeElseRead,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_targetAddr,
  output logic [2:0]   o_subAddr,
  output logic [15:0]  o_writeMask,
  output logic [255:0] o_dataClient,
  input  logic         i_busyClient,
  input  logic         i_dataValidClient,
  input  logic [255:0] i_dataClient
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_BUSY = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  logic [2:0]   state;
  logic [2:0]   gap_cnt;
  logic [1:0]   owner;
  logic [1:0]   winner;
  logic [2:0]   ack_q;
  logic [2:0]   done_q;
  logic         hold_write;
  logic [1:0]   hold_size;
  logic [14:0]  hold_addr;
  logic [2:0]   hold_sub;
  logic [15:0]  hold_mask;
  logic [255:0] hold_data;
  logic         sel_write;
  logic [1:0]   sel_size;
  logic [14:0]  sel_addr;
  logic [2:0]   sel_sub;
  logic [15:0]  sel_mask;
  logic [255:0] sel_data;

`ifdef PSX_ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant;

  // Search starts just after the last grant and wraps around.
  always_comb begin
    winner = 2'd0;
    case (last_grant)
      2'd0:    winner = i_reqCmd[1] ? 2'd1 : (i_reqCmd[2] ? 2'd2 : 2'd0);
      2'd1:    winner = i_reqCmd[2] ? 2'd2 : (i_reqCmd[0] ? 2'd0 : 2'd1);
      default: winner = i_reqCmd[0] ? 2'd0 : (i_reqCmd[1] ? 2'd1 : 2'd2);
    endcase
  end
`else
  always_comb begin
    winner = i_reqCmd[0] ? 2'd0 : (i_reqCmd[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    sel_write = i_reqWrite[0];
    sel_size  = i_reqSize[1:0];
    sel_addr  = i_reqAddr[14:0];
    sel_sub   = i_reqSub[2:0];
    sel_mask  = i_reqMask[15:0];
    sel_data  = i_reqData[255:0];
    case (winner)
      2'd1: begin
        sel_write = i_reqWrite[1];
        sel_size  = i_reqSize[3:2];
        sel_addr  = i_reqAddr[29:15];
        sel_sub   = i_reqSub[5:3];
        sel_mask  = i_reqMask[31:16];
        sel_data  = i_reqData[511:256];
      end
      2'd2: begin
        sel_write = i_reqWrite[2];
        sel_size  = i_reqSize[5:4];
        sel_addr  = i_reqAddr[44:30];
        sel_sub   = i_reqSub[8:6];
        sel_mask  = i_reqMask[47:32];
        sel_data  = i_reqData[767:512];
      end
      default: ;
    endcase
  end

  // ARM exists because the bridge raises busy only one cycle after the command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= 3'd0;
      owner      <= 2'd0;
      ack_q      <= 3'd0;
      done_q     <= 3'd0;
      hold_write <= 1'b0;
      hold_size  <= 2'd0;
      hold_addr  <= 15'd0;
      hold_sub   <= 3'd0;
      hold_mask  <= 16'd0;
      hold_data  <= 256'd0;
`ifdef PSX_ARB_ROUND_ROBIN_EN
      last_grant <= 2'd2;
`endif
    end else begin
      ack_q  <= 3'd0;
      done_q <= 3'd0;
      case (state)
        ST_IDLE: begin
          if (|i_reqCmd) begin
            owner      <= winner;
            hold_write <= sel_write;
            hold_size  <= sel_size;
            hold_addr  <= sel_addr;
            hold_sub   <= sel_sub;
            hold_mask  <= sel_mask;
            hold_data  <= sel_data;
            ack_q      <= 3'b001 << winner;
            state      <= ST_CMD;
`ifdef PSX_ARB_ROUND_ROBIN_EN
            last_grant <= winner;
`endif
          end
        end
        ST_CMD: state <= ST_ARM;
        ST_ARM: state <= ST_BUSY;
        ST_BUSY: begin
          if (!i_busyClient) begin
            done_q <= 3'b001 << owner;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= 3'd0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= 3'd0;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding registers feed the bridge continuously; the bridge reads size for the whole burst.
  assign o_command       = (state == ST_CMD);
  assign o_ack           = ack_q;
  assign o_done          = done_q;
  assign o_writeElseRead = hold_write;
  assign o_commandSize   = hold_size;
  assign o_targetAddr    = hold_addr;
  assign o_subAddr       = hold_sub;
  assign o_writeMask     = hold_mask;
  assign o_dataClient    = hold_data;
  assign o_rdData        = i_dataClient;
  assign o_rdValid       = (state == ST_BUSY && !hold_write && i_dataValidClient) ?
                           (3'b001 << owner) : 3'b000;

endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Bench for psx_mem_arbiter: bridge model plus a scoreboard of expected transactions.
// Expected grant order follows PSX_ARB_ROUND_ROBIN_EN when the build defines it.
module tb_psx_mem_arbiter;

  localparam int GAP = 3;

  typedef struct {
    logic [1:0]   owner;
    logic         wr;
    logic [1:0]   size;
    logic [14:0]  addr;
    logic [2:0]   sub;
    logic [15:0]  mask;
    logic [255:0] data;
    logic [255:0] rd;
  } txn_t;

  logic         clk;
  logic         rst;
  logic [2:0]   req_cmd;
  logic [2:0]   req_write;
  logic [5:0]   req_size;
  logic [44:0]  req_addr;
  logic [8:0]   req_sub;
  logic [47:0]  req_mask;
  logic [767:0] req_data;
  logic [2:0]   ack;
  logic [2:0]   done;
  logic [2:0]   rd_valid;
  logic [255:0] rd_data;
  logic         command;
  logic         write_else_read;
  logic [1:0]   command_size;
  logic [14:0]  target_addr;
  logic [2:0]   sub_addr;
  logic [15:0]  write_mask;
  logic [255:0] data_client;
  logic         bridge_busy;
  logic         bridge_dv;
  logic         spur_dv;
  logic         dv_in;
  logic [255:0] bridge_data;

  int           checks;
  int           errors;
  int           busy_len;
  logic [255:0] rd_pattern;
  txn_t         exp_q[$];
  int           gap_q[$];
  int           done_count;
  int           want_dones;
  txn_t         fld0, fld1, fld2;

  assign dv_in = bridge_dv | spur_dv;

  psx_mem_arbiter #(.GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reqCmd(req_cmd), .i_reqWrite(req_write), .i_reqSize(req_size),
    .i_reqAddr(req_addr), .i_reqSub(req_sub), .i_reqMask(req_mask), .i_reqData(req_data),
    .o_ack(ack), .o_done(done), .o_rdValid(rd_valid), .o_rdData(rd_data),
    .o_command(command), .o_writeElseRead(write_else_read), .o_commandSize(command_size),
    .o_targetAddr(target_addr), .o_subAddr(sub_addr), .o_writeMask(write_mask),
    .o_dataClient(data_client),
    .i_busyClient(bridge_busy), .i_dataValidClient(dv_in), .i_dataClient(bridge_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int n, input logic wr, input logic [1:0] size,
                                input logic [14:0] addr, input logic [2:0] sub,
                                input logic [15:0] mask, input logic [255:0] data);
    txn_t t;
    t.owner = 2'(n); t.wr = wr; t.size = size; t.addr = addr;
    t.sub = sub; t.mask = mask; t.data = data; t.rd = '0;
    case (n)
      0: begin
        req_write[0] = wr; req_size[1:0] = size; req_addr[14:0] = addr;
        req_sub[2:0] = sub; req_mask[15:0] = mask; req_data[255:0] = data; fld0 = t;
      end
      1: begin
        req_write[1] = wr; req_size[3:2] = size; req_addr[29:15] = addr;
        req_sub[5:3] = sub; req_mask[31:16] = mask; req_data[511:256] = data; fld1 = t;
      end
      default: begin
        req_write[2] = wr; req_size[5:4] = size; req_addr[44:30] = addr;
        req_sub[8:6] = sub; req_mask[47:32] = mask; req_data[767:512] = data; fld2 = t;
      end
    endcase
  endtask

  task automatic push_expect(input int n, input logic [255:0] rd);
    txn_t t;
    case (n)
      0:       t = fld0;
      1:       t = fld1;
      default: t = fld2;
    endcase
    t.rd = rd;
    exp_q.push_back(t);
    want_dones++;
  endtask

  task automatic wait_ack(input logic [2:0] exp, input bit check_latency);
    int edges;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (ack == 3'b000 && edges < 60);
    check_output("ack_grant", 256'(ack), 256'(exp));
    check_output("cmd_with_ack", 256'(command), 256'(1'b1));
    if (check_latency) check_output("ack_latency", 256'(edges), 256'(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_count < want_dones; i++) @(negedge clk);
    check_output("done_count", 256'(done_count), 256'(want_dones));
  endtask

  function automatic int exp_winner(input int k);
`ifdef PSX_ARB_ROUND_ROBIN_EN
    return k % 3;
`else
    return k - k;
`endif
  endfunction

  // Bridge model: busy rises the cycle after the command and read data returns as busy falls.
  initial begin
    int   cnt;
    logic bwr;
    logic cmd_seen;
    logic cmd_wr;
    bridge_busy = 1'b0; bridge_dv = 1'b0; bridge_data = '0;
    cnt = 0; bwr = 1'b0;
    forever begin
      @(negedge clk);
      cmd_seen = command;
      cmd_wr   = write_else_read;
      @(posedge clk);
      #1;
      if (rst) begin
        bridge_busy = 1'b0; bridge_dv = 1'b0; cnt = 0;
      end else begin
        bridge_dv = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bridge_busy = 1'b0;
            if (!bwr) begin
              bridge_dv   = 1'b1;
              bridge_data = rd_pattern;
            end
          end
        end else if (cmd_seen) begin
          bridge_busy = 1'b1;
          cnt = busy_len;
          bwr = cmd_wr;
        end
      end
    end
  end

  // Scoreboard: command fields checked against the queue head, popped on o_done.
  initial begin
    int       cyc;
    int       last_done_cyc;
    bit       have_done;
    bit       cmd_prev;
    bit       in_txn;
    logic [2:0]   rd_seen;
    logic [255:0] rd_cap;
    txn_t     cur;
    cyc = 0; last_done_cyc = 0; have_done = 0; cmd_prev = 0; in_txn = 0;
    rd_seen = '0; rd_cap = '0; done_count = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cmd_prev = 0; in_txn = 0; rd_seen = '0;
      end else begin
        if (command) begin
          check_output("cmd_twice", 256'(cmd_prev), 256'(1'b0));
          check_output("cmd_expected", 256'(exp_q.size() != 0), 256'(1'b1));
          if (exp_q.size() != 0) begin
            check_output("cmd_write", 256'(write_else_read), 256'(exp_q[0].wr));
            check_output("cmd_size", 256'(command_size), 256'(exp_q[0].size));
            check_output("cmd_addr", 256'(target_addr), 256'(exp_q[0].addr));
            check_output("cmd_sub", 256'(sub_addr), 256'(exp_q[0].sub));
            check_output("cmd_mask", 256'(write_mask), 256'(exp_q[0].mask));
            check_output("cmd_data", data_client, exp_q[0].data);
            in_txn = 1;
          end
          if (have_done) gap_q.push_back(cyc - last_done_cyc - 1);
        end else if (in_txn && done == 3'b000 && exp_q.size() != 0) begin
          check_output("size_stable", 256'(command_size), 256'(exp_q[0].size));
        end
        cmd_prev = command;
        if (rd_valid != 3'b000) begin
          rd_seen = rd_seen | rd_valid;
          rd_cap  = rd_data;
        end
        if (done != 3'b000) begin
          done_count++;
          last_done_cyc = cyc;
          have_done = 1;
          in_txn = 0;
          check_output("done_expected", 256'(exp_q.size() != 0), 256'(1'b1));
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check_output("done_owner", 256'(done), 256'(3'b001 << cur.owner));
            check_output("rdvalid_owner", 256'(rd_seen),
                         256'(cur.wr ? 3'b000 : (3'b001 << cur.owner)));
            if (!cur.wr) check_output("rd_data", rd_cap, cur.rd);
          end
          rd_seen = '0;
        end
      end
    end
  end

  initial begin
    int base;
    checks = 0; errors = 0; want_dones = 0;
    rst = 1'b1; spur_dv = 1'b0; busy_len = 6;
    req_cmd = '0; req_write = '0; req_size = '0; req_addr = '0;
    req_sub = '0; req_mask = '0; req_data = '0;
    rd_pattern = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    // Requests during reset must not be granted.
    repeat (2) @(negedge clk);
    req_cmd = 3'b111;
    @(negedge clk);
    check_output("rst_ack", 256'(ack), 256'(3'b000));
    check_output("rst_done", 256'(done), 256'(3'b000));
    check_output("rst_command", 256'(command), 256'(1'b0));
    check_output("rst_rdvalid", 256'(rd_valid), 256'(3'b000));
    check_output("rst_addr", 256'(target_addr), 256'(15'd0));
    check_output("rst_size", 256'(command_size), 256'(2'd0));
    check_output("rst_mask", 256'(write_mask), 256'(16'd0));
    check_output("rst_data", data_client, 256'd0);
    req_cmd = 3'b000;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_no_cmd", 256'(command), 256'(1'b0));

    // GPU 32-byte read.
    apply_stimulus(0, 1'b0, 2'd1, 15'h1234, 3'd0, 16'h0000, 256'd0);
    push_expect(0, rd_pattern);
    req_cmd = 3'b001;
    wait_ack(3'b001, 1'b1);
    req_cmd = 3'b000;
    wait_done();
    repeat (6) @(negedge clk);

    // Stray data-valid while idle after a read.
    spur_dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rdvalid_spurious", 256'(rd_valid), 256'(3'b000));
    end
    spur_dv = 1'b0;
    repeat (2) @(negedge clk);

    // CPU 4-byte write.
    apply_stimulus(2, 1'b1, 2'd2, 15'h0042, 3'd1, 16'h0003, 256'hDEADBEEF);
    push_expect(2, 256'd0);
    req_cmd = 3'b100;
    wait_ack(3'b100, 1'b1);
    check_output("write_low_word", 256'(data_client[31:0]), 256'(32'hDEADBEEF));
    req_cmd = 3'b000;
    wait_done();
    repeat (8) @(negedge clk);

    // All requesters held continuously.
    apply_stimulus(0, 1'b0, 2'd1, 15'h0100, 3'd2, 16'h0000, 256'h11);
    apply_stimulus(1, 1'b0, 2'd0, 15'h0200, 3'd4, 16'h0000, 256'h22);
    apply_stimulus(2, 1'b1, 2'd2, 15'h0300, 3'd5, 16'hF0F0, 256'h3333_4444);
    for (int k = 0; k < 6; k++) push_expect(exp_winner(k), rd_pattern);
    gap_q.delete();
    req_cmd = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(3'b001 << exp_winner(k), 1'b0);
      if (k == 5) req_cmd = 3'b000;
    end
    wait_done();
    check_output("gap_count", 256'(gap_q.size()), 256'(6));
    for (int i = 1; i < 6; i++)
      if (i < gap_q.size()) check_output("gap_cycles", 256'(gap_q[i]), 256'(GAP));
    repeat (8) @(negedge clk);

    // Reset in the middle of a BUSY phase.
    apply_stimulus(1, 1'b0, 2'd0, 15'h7FFF, 3'd7, 16'hFFFF, {8{32'hA5A5_5A5A}});
    push_expect(1, rd_pattern);
    req_cmd = 3'b010;
    wait_ack(3'b010, 1'b1);
    req_cmd = 3'b000;
    repeat (3) @(negedge clk);
    base = done_count;
    rst = 1'b1;
    #1;
    exp_q.delete();
    want_dones = base;
    check_output("abort_ack", 256'(ack), 256'(3'b000));
    check_output("abort_done", 256'(done), 256'(3'b000));
    check_output("abort_command", 256'(command), 256'(1'b0));
    check_output("abort_rdvalid", 256'(rd_valid), 256'(3'b000));
    check_output("abort_addr", 256'(target_addr), 256'(15'd0));
    check_output("abort_mask", 256'(write_mask), 256'(16'd0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_output("abort_no_done", 256'(done_count), 256'(base));

    apply_stimulus(1, 1'b0, 2'd1, 15'h0ABC, 3'd0, 16'h0000, 256'd0);
    push_expect(1, rd_pattern);
    req_cmd = 3'b010;
    wait_ack(3'b010, 1'b1);
    req_cmd = 3'b000;
    wait_done();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
